// File: rtl/adder_pipe_pkg.sv
// adder_pipe_pkg: op encoding and default geometry for the pipelined adder.
package adder_pipe_pkg;
   localparam logic OP_ADD     = 1'b0;
   localparam logic OP_SUB     = 1'b1;
   localparam int   DEF_WIDTH  = 32;
   localparam int   DEF_STAGES = 4;
endpackage

// File: rtl/adder_pipe_seg_adder.sv
// seg_adder: W-bit combinational adder segment with carry-in and carry-out.
module seg_adder #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co
);
   assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
endmodule

// File: rtl/adder_pipe.sv
// adder_pipe: STAGES-segment pipelined add/sub with valid/ready flow control.
// Define ADDER_PIPE_FLAGS_EN to add registered ovf/zero outputs.
module adder_pipe
   import adder_pipe_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             cin,
   input  logic             op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef ADDER_PIPE_FLAGS_EN
   ,
   output logic             ovf,
   output logic             zero
`endif
);
   localparam int SEG = WIDTH / STAGES;
   localparam int L   = STAGES - 1;
   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;
   // r carries finished sum bits below the live segment and untouched in1 bits above it;
   // b shrinks by one segment per stage so only unconsumed operand bits are registered.
   for (genvar k = 0; k < STAGES; k++) begin : g_st
      localparam int LO = k * SEG;
      logic [WIDTH-1:0]    r_i, r_o;
      logic [WIDTH-LO-1:0] b_i;
      logic                c_i, v_i, c_o;
      logic [SEG-1:0]      s_seg;
      if (k == 0) begin : g_src
         always_comb begin
            r_i = in1;
            b_i = (op == OP_SUB) ? ~in2 : in2;
            c_i = (op == OP_SUB) ? ~cin : cin;
            v_i = in_valid;
         end
      end else begin : g_reg
         logic [WIDTH-1:0]    r_d, r_q;
         logic [WIDTH-LO-1:0] b_d, b_q;
         logic                c_d, c_q, v_d, v_q;
         always_comb begin
            r_d = g_st[k-1].r_o;
            b_d = g_st[k-1].b_i[WIDTH-LO+SEG-1:SEG];
            c_d = g_st[k-1].c_o;
            v_d = g_st[k-1].v_i;
         end
         always_ff @(posedge clk) begin
            if (reset) begin
               r_q <= '0;
               b_q <= '0;
               c_q <= 1'b0;
               v_q <= 1'b0;
            end else if (adv) begin
               r_q <= r_d;
               b_q <= b_d;
               c_q <= c_d;
               v_q <= v_d;
            end
         end
         always_comb begin
            r_i = r_q;
            b_i = b_q;
            c_i = c_q;
            v_i = v_q;
         end
      end
      seg_adder #(.W(SEG)) u_seg (
         .a  (r_i[LO +: SEG]),
         .b  (b_i[SEG-1:0]),
         .ci (c_i),
         .s  (s_seg),
         .co (c_o)
      );
      always_comb begin
         r_o = r_i;
         r_o[LO +: SEG] = s_seg;
      end
   end
   logic [WIDTH-1:0] sum_d, sum_q;
   logic             cout_d, cout_q, out_valid_d, out_valid_q;
   always_comb begin
      sum_d       = g_st[L].r_o;
      cout_d      = g_st[L].c_o;
      out_valid_d = g_st[L].v_i;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         sum_q       <= '0;
         cout_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (adv) begin
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         out_valid_q <= out_valid_d;
      end
   end
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign out_valid = out_valid_q;
`ifdef ADDER_PIPE_FLAGS_EN
   logic ovf_d, ovf_q, zero_d, zero_q;
   // carry into the MSB is recovered as a^b^s at that bit
   always_comb begin
      ovf_d  = g_st[L].r_i[WIDTH-1] ^ g_st[L].b_i[SEG-1] ^ sum_d[WIDTH-1] ^ cout_d;
      zero_d = (sum_d == '0);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (adv) begin
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
      end
   end
   assign ovf  = ovf_q;
   assign zero = zero_q;
`endif
endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: directed and random checks of adder_pipe (WIDTH=32, STAGES=4).
module tb_adder_pipe;
   logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, cin = 1'b0, op = 1'b0, out_ready = 1'b1;
   logic        in_ready, out_valid, cout;
   logic [31:0] in1 = '0, in2 = '0, sum;
`ifdef ADDER_PIPE_FLAGS_EN
   logic        ovf, zero;
`endif
   int checks = 0, errors = 0;

   adder_pipe #(.WIDTH(32), .STAGES(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in1       (in1),
      .in2       (in2),
      .cin       (cin),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
`ifdef ADDER_PIPE_FLAGS_EN
      ,
      .ovf       (ovf),
      .zero      (zero)
`endif
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1; in_valid = 1'b1; in1 = 32'h1; in2 = 32'h1;
      step; step;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (sum !== 32'h0) begin errors++; $display("FAIL reset_sum got %h want 0", sum); end
      checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", cout); end
`ifdef ADDER_PIPE_FLAGS_EN
      checks++; if ({ovf, zero} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {ovf, zero}); end
`endif
      reset = 1'b0; in_valid = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
   endtask

   task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b, input logic c,
                          input logic o, input logic [31:0] es, input logic ec, input logic eo, input logic ez);
      int n;
      in1 = a; in2 = b; cin = c; op = o; in_valid = 1'b1; out_ready = 1'b1;
      step;
      in_valid = 1'b0; in1 = ~a; in2 = ~b; cin = ~c; op = ~o;
      n = 1;
      while (out_valid !== 1'b1 && n < 20) begin step; n++; end
      checks++; if (n != 4) begin errors++; $display("FAIL %s latency got %0d want 4", name, n); end
      checks++; if (sum !== es) begin errors++; $display("FAIL %s sum got %h want %h", name, sum, es); end
      checks++; if (cout !== ec) begin errors++; $display("FAIL %s cout got %b want %b", name, cout, ec); end
`ifdef ADDER_PIPE_FLAGS_EN
      checks++; if (ovf !== eo) begin errors++; $display("FAIL %s ovf got %b want %b", name, ovf, eo); end
      checks++; if (zero !== ez) begin errors++; $display("FAIL %s zero got %b want %b", name, zero, ez); end
`endif
      step;
   endtask

   task automatic test_add;
      run_one("add_wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
      run_one("add_cin",    32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, 1'b0);
      run_one("add_segcar", 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0);
      run_one("add_negneg", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
   endtask

   task automatic test_sub;
      run_one("sub_5m7",    32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      run_one("sub_7m5",    32'd7, 32'd5, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
      run_one("sub_borrow", 32'd7, 32'd5, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
      run_one("sub_equal",  32'd5, 32'd5, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
      run_one("sub_0m1",    32'd0, 32'd1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_overflow;
      run_one("ovf_add", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      run_one("ovf_sub", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic test_back_to_back;
      int sent = 0, got = 0;
      logic [31:0] held = '0;
      logic held_v = 1'b0;
      op = 1'b0; cin = 1'b0;
      for (int c = 0; c < 30; c++) begin
         out_ready = !(c >= 5 && c < 8);
         in_valid  = (sent < 6);
         in1 = 32'(sent + 1); in2 = 32'(16 * (sent + 1));
         #1;
         if (!out_ready) begin
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_stall c=%0d in_ready=%b out_valid=%b want 0/1", c, in_ready, out_valid); end
            if (held_v) begin
               checks++; if (sum !== held) begin errors++; $display("FAIL b2b_hold sum got %h want %h", sum, held); end
            end
            held = sum; held_v = 1'b1;
         end
         if (out_valid && out_ready) begin
            got++;
            checks++; if (sum !== 32'(17 * got)) begin errors++; $display("FAIL b2b_result %0d got %h want %h", got, sum, 32'(17 * got)); end
         end
         if (in_valid && in_ready) sent++;
         step;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++; if (got != 6 || sent != 6) begin errors++; $display("FAIL b2b_count got %0d/%0d want 6/6", got, sent); end
   endtask

   task automatic test_reset_mid;
      int bad = 0;
      op = 1'b0; cin = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in1 = 32'(i + 1); in2 = 32'd2;
         step;
      end
      in1 = 32'd9; reset = 1'b1;
      step; step;
      reset = 1'b0; in_valid = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_after in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
      for (int i = 0; i < 10; i++) begin
         if (out_valid !== 1'b0) bad++;
         step;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL rst_mid_discard got %0d stray results want 0", bad); end
      run_one("post_reset", 32'd40, 32'd2, 1'b0, 1'b0, 32'd42, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_random;
      logic [34:0] q[$];
      logic [34:0] e;
      logic [32:0] r;
      logic [31:0] bb;
      int n_in = 0, n_out = 0, cyc = 0;
      while (n_out < 10000 && cyc < 80000) begin
         in_valid  = (n_in < 10000) && ($urandom_range(3) != 0);
         in1 = $urandom; in2 = ($urandom_range(7) == 0) ? in1 : $urandom;
         cin = 1'($urandom_range(1)); op = 1'($urandom_range(1));
         out_ready = ($urandom_range(3) != 0);
         #1;
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL rand_extra result %h with empty model queue", sum);
            end else begin
               e = q.pop_front();
`ifdef ADDER_PIPE_FLAGS_EN
               if ({zero, ovf, cout, sum} !== e) begin errors++; $display("FAIL rand_result #%0d got %h want %h", n_out, {zero, ovf, cout, sum}, e); end
`else
               if ({cout, sum} !== e[32:0]) begin errors++; $display("FAIL rand_result #%0d got %h want %h", n_out, {cout, sum}, e[32:0]); end
`endif
            end
            n_out++;
         end
         if (in_valid && in_ready) begin
            bb = op ? ~in2 : in2;
            r  = {1'b0, in1} + {1'b0, bb} + 33'(op ? !cin : cin);
            q.push_back({r[31:0] == 32'h0, (in1[31] == bb[31]) && (r[31] != in1[31]), r});
            n_in++;
         end
         step;
         cyc++;
      end
      in_valid = 1'b0;
      checks++; if (n_out != 10000 || q.size() != 0) begin errors++; $display("FAIL rand_count got %0d outputs, %0d pending want 10000/0", n_out, q.size()); end
   endtask

   initial begin
      test_reset;
      test_add;
      test_sub;
      test_overflow;
      test_back_to_back;
      test_reset_mid;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
